exc_commit_ctrl: RTL and testbench

//  WB-stage exception/interrupt arbiter; drives the CSR exception-entry interface (is_exc, excode, esubcode,

---
 rtl/exc_commit_ctrl_if.sv | 40 ++++
 rtl/exc_commit_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_exc_commit_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/exc_commit_ctrl_if.sv
// WB-stage instruction bus and CSR exception-entry bus for exc_commit_ctrl.
// slave : the arbiter itself (consumes WB/CSR status, drives CSR events)
// master: the pipeline/CSR side (drives WB/CSR status, observes events)
interface exc_commit_ctrl_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_pc;
  logic [3:0]  wb_fexc;
  logic [3:0]  wb_dexc;
  logic [6:0]  wb_mexc;
  logic [31:0] wb_vaddr;
  logic        wb_ertn;
  logic        wb_refetch;
  logic        wb_idle;
  logic [11:0] is;
  logic [11:0] lie;
  logic        ie;
  logic        exlike;
  logic        is_exc;
  logic        is_ertn;
  logic        is_fetch_again;
  logic [5:0]  excode;
  logic [8:0]  esubcode;
  logic [31:0] badvaddr;
  logic [31:0] csr_pc;

  modport slave (
    input  wb_valid, wb_pc, wb_fexc, wb_dexc, wb_mexc, wb_vaddr,
           wb_ertn, wb_refetch, wb_idle, is, lie, ie, exlike,
    output wb_ready, is_exc, is_ertn, is_fetch_again, excode, esubcode,
           badvaddr, csr_pc
  );

  modport master (
    output wb_valid, wb_pc, wb_fexc, wb_dexc, wb_mexc, wb_vaddr,
           wb_ertn, wb_refetch, wb_idle, is, lie, ie, exlike,
    input  wb_ready, is_exc, is_ertn, is_fetch_again, excode, esubcode,
           badvaddr, csr_pc
  );
endinterface

// File: rtl/exc_commit_ctrl.sv
// WB-stage exception/interrupt arbiter.
// Picks the highest-priority trap for the retiring instruction, emits one
// registered event pulse to the CSR block, then holds the pipeline flushed
// until the CSR redirect strobe (exlike) or a FLUSH_MAX-cycle timeout.
// Optional build macro: IDLE_WAKE_EN (idle instruction waits for an interrupt).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_RUN     | accepting WB instructions (wb_ready=1)
// S_FLUSH   | event issued, younger stages killed, waiting for exlike
// S_IDLE    | (IDLE_WAKE_EN only) idle retired, waiting for int_pend
module exc_commit_ctrl #(
  parameter int FLUSH_MAX = 8
) (
  input  logic               clk,
  input  logic               reset,
  exc_commit_ctrl_if.slave   bus,
  output logic               commit_valid,
  output logic               flush,
  output logic               flush_timeout
);

  localparam int CW = $clog2(FLUSH_MAX);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1
`ifdef IDLE_WAKE_EN
    , S_IDLE  = 2'd2
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        is_exc_q, is_exc_d;
  logic        is_ertn_q, is_ertn_d;
  logic        fetch_again_q, fetch_again_d;
  logic [5:0]  excode_q, excode_d;
  logic [8:0]  esubcode_q, esubcode_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] csr_pc_q, csr_pc_d;
  logic        commit_q, commit_d;
  logic        timeout_q, timeout_d;
`ifdef IDLE_WAKE_EN
  logic [31:0] idle_pc_q, idle_pc_d;
`endif

  logic        int_pend;
  logic        trap;
  logic [5:0]  trap_code;
  logic [8:0]  trap_sub;
  logic [31:0] trap_badv;

  assign int_pend = bus.ie & (|(bus.is & bus.lie));

  // Fixed-priority trap encoder: interrupt, then fetch, decode, memory faults
  always_comb begin
    trap      = 1'b1;
    trap_code = 6'h00;
    trap_sub  = 9'd0;
    trap_badv = 32'd0;
    if (int_pend) begin
      trap_code = 6'h00;
    end else if (bus.wb_fexc[3]) begin
      trap_code = 6'h08; trap_badv = bus.wb_pc;
    end else if (bus.wb_fexc[2]) begin
      trap_code = 6'h3F; trap_badv = bus.wb_pc;
    end else if (bus.wb_fexc[1]) begin
      trap_code = 6'h03; trap_badv = bus.wb_pc;
    end else if (bus.wb_fexc[0]) begin
      trap_code = 6'h07; trap_badv = bus.wb_pc;
    end else if (bus.wb_dexc[3]) begin
      trap_code = 6'h0D;
    end else if (bus.wb_dexc[2]) begin
      trap_code = 6'h0E;
    end else if (bus.wb_dexc[1]) begin
      trap_code = 6'h0B;
    end else if (bus.wb_dexc[0]) begin
      trap_code = 6'h0C;
    end else if (bus.wb_mexc[6]) begin
      trap_code = 6'h09; trap_badv = bus.wb_vaddr;
    end else if (bus.wb_mexc[5]) begin
      trap_code = 6'h08; trap_sub = 9'd1; trap_badv = bus.wb_vaddr;
    end else if (bus.wb_mexc[4]) begin
      trap_code = 6'h3F; trap_badv = bus.wb_vaddr;
    end else if (bus.wb_mexc[3]) begin
      trap_code = 6'h01; trap_badv = bus.wb_vaddr;
    end else if (bus.wb_mexc[2]) begin
      trap_code = 6'h02; trap_badv = bus.wb_vaddr;
    end else if (bus.wb_mexc[1]) begin
      trap_code = 6'h04; trap_badv = bus.wb_vaddr;
    end else if (bus.wb_mexc[0]) begin
      trap_code = 6'h07; trap_badv = bus.wb_vaddr;
    end else begin
      trap = 1'b0;
    end
  end

  // Next state, flush counter and next-cycle event outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_exc_d      = 1'b0;
    is_ertn_d     = 1'b0;
    fetch_again_d = 1'b0;
    excode_d      = 6'h00;
    esubcode_d    = 9'd0;
    badvaddr_d    = 32'd0;
    csr_pc_d      = 32'd0;
    commit_d      = 1'b0;
    timeout_d     = timeout_q;
`ifdef IDLE_WAKE_EN
    idle_pc_d     = idle_pc_q;
`endif
    case (state_q)
      S_RUN: begin
        if (bus.wb_valid) begin
          if (trap) begin
            is_exc_d   = 1'b1;
            excode_d   = trap_code;
            esubcode_d = trap_sub;
            badvaddr_d = trap_badv;
            csr_pc_d   = bus.wb_pc;
            state_d    = S_FLUSH;
            cnt_d      = '0;
          end else if (bus.wb_ertn) begin
            is_ertn_d = 1'b1;
            commit_d  = 1'b1;
            csr_pc_d  = bus.wb_pc;
            state_d   = S_FLUSH;
            cnt_d     = '0;
          end else if (bus.wb_refetch) begin
            fetch_again_d = 1'b1;
            commit_d      = 1'b1;
            csr_pc_d      = bus.wb_pc;
            state_d       = S_FLUSH;
            cnt_d         = '0;
`ifdef IDLE_WAKE_EN
          end else if (bus.wb_idle) begin
            commit_d  = 1'b1;
            idle_pc_d = bus.wb_pc + 32'd4;
            state_d   = S_IDLE;
`endif
          end else begin
            commit_d = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.exlike) begin
          state_d = S_RUN;
        end else if (cnt_q == CW'(FLUSH_MAX - 1)) begin
          state_d   = S_RUN;
          timeout_d = 1'b1;
        end
      end
`ifdef IDLE_WAKE_EN
      S_IDLE: begin
        if (int_pend) begin
          is_exc_d = 1'b1;
          excode_d = 6'h00;
          csr_pc_d = idle_pc_q;
          state_d  = S_FLUSH;
          cnt_d    = '0;
        end
      end
`endif
      default: state_d = S_RUN;
    endcase
  end

  // State, counter and registered CSR event outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_RUN;
      cnt_q         <= '0;
      is_exc_q      <= 1'b0;
      is_ertn_q     <= 1'b0;
      fetch_again_q <= 1'b0;
      excode_q      <= 6'h00;
      esubcode_q    <= 9'd0;
      badvaddr_q    <= 32'd0;
      csr_pc_q      <= 32'd0;
      commit_q      <= 1'b0;
      timeout_q     <= 1'b0;
`ifdef IDLE_WAKE_EN
      idle_pc_q     <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_exc_q      <= is_exc_d;
      is_ertn_q     <= is_ertn_d;
      fetch_again_q <= fetch_again_d;
      excode_q      <= excode_d;
      esubcode_q    <= esubcode_d;
      badvaddr_q    <= badvaddr_d;
      csr_pc_q      <= csr_pc_d;
      commit_q      <= commit_d;
      timeout_q     <= timeout_d;
`ifdef IDLE_WAKE_EN
      idle_pc_q     <= idle_pc_d;
`endif
    end
  end

  assign bus.wb_ready       = (state_q == S_RUN);
  assign flush              = (state_q == S_FLUSH);
  assign bus.is_exc         = is_exc_q;
  assign bus.is_ertn        = is_ertn_q;
  assign bus.is_fetch_again = fetch_again_q;
  assign bus.excode         = excode_q;
  assign bus.esubcode       = esubcode_q;
  assign bus.badvaddr       = badvaddr_q;
  assign bus.csr_pc         = csr_pc_q;
  assign commit_valid       = commit_q;
  assign flush_timeout      = timeout_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed bench for exc_commit_ctrl (default FLUSH_MAX=8).
module tb_exc_commit_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic commit_valid, flush, flush_timeout;
  int   n_vec = 0;
  int   n_err = 0;

  exc_commit_ctrl_if bus();

  exc_commit_ctrl #(.FLUSH_MAX(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .commit_valid  (commit_valid),
    .flush         (flush),
    .flush_timeout (flush_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [31:0] pc, input logic [3:0] f, input logic [3:0] d,
                        input logic [6:0] m, input logic [31:0] va,
                        input logic er, input logic rf, input logic id);
    bus.wb_valid   = 1'b1;
    bus.wb_pc      = pc;
    bus.wb_fexc    = f;
    bus.wb_dexc    = d;
    bus.wb_mexc    = m;
    bus.wb_vaddr   = va;
    bus.wb_ertn    = er;
    bus.wb_refetch = rf;
    bus.wb_idle    = id;
    tick();
    bus.wb_valid   = 1'b0;
    bus.wb_fexc    = 4'd0;
    bus.wb_dexc    = 4'd0;
    bus.wb_mexc    = 7'd0;
    bus.wb_ertn    = 1'b0;
    bus.wb_refetch = 1'b0;
    bus.wb_idle    = 1'b0;
  endtask

  task automatic release_flush(input string tag);
    bus.exlike = 1'b1;
    tick();
    bus.exlike = 1'b0;
    chk({tag, "_ready"}, bus.wb_ready, 1);
    chk({tag, "_flush"}, flush, 0);
  endtask

  initial begin
    bus.wb_valid = 0; bus.wb_pc = 0; bus.wb_fexc = 0; bus.wb_dexc = 0;
    bus.wb_mexc = 0; bus.wb_vaddr = 0; bus.wb_ertn = 0; bus.wb_refetch = 0;
    bus.wb_idle = 0; bus.is = 0; bus.lie = 0; bus.ie = 0; bus.exlike = 0;

    // reset values
    #12;
    chk("rst_ready", bus.wb_ready, 1);
    chk("rst_exc", bus.is_exc, 0);
    chk("rst_commit", commit_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_tmo", flush_timeout, 0);
    tick();
    reset = 1'b1;
    tick();

    // ALE memory fault
    accept(32'h1C000100, 4'b0000, 4'b0000, 7'b1000000, 32'h00001003, 0, 0, 0);
    chk("ale_exc", bus.is_exc, 1);
    chk("ale_code", bus.excode, 32'h09);
    chk("ale_sub", bus.esubcode, 0);
    chk("ale_badv", bus.badvaddr, 32'h00001003);
    chk("ale_pc", bus.csr_pc, 32'h1C000100);
    chk("ale_commit", commit_valid, 0);
    chk("ale_flush", flush, 1);
    chk("ale_ready", bus.wb_ready, 0);
    release_flush("ale");
    chk("ale_pulse", bus.is_exc, 0);

    // interrupt beats ADEF
    bus.ie = 1; bus.is = 12'h004; bus.lie = 12'h004;
    accept(32'h1C000110, 4'b1000, 4'b0000, 7'b0000000, 32'h0000BEEF, 0, 0, 0);
    bus.ie = 0; bus.is = 0; bus.lie = 0;
    chk("int_exc", bus.is_exc, 1);
    chk("int_code", bus.excode, 32'h00);
    chk("int_pc", bus.csr_pc, 32'h1C000110);
    chk("int_badv", bus.badvaddr, 0);
    release_flush("int");

    // masked interrupt (ie=0) lets INE through
    bus.ie = 0; bus.is = 12'h800; bus.lie = 12'h800;
    accept(32'h1C000120, 4'b0000, 4'b1000, 7'b0000000, 32'h0, 0, 0, 0);
    bus.is = 0; bus.lie = 0;
    chk("ine_code", bus.excode, 32'h0D);
    chk("ine_badv", bus.badvaddr, 0);
    release_flush("ine");

    // TLBR fetch beats all decode faults, badvaddr=pc
    accept(32'h1C000130, 4'b0100, 4'b1111, 7'b1111111, 32'h00002000, 0, 0, 0);
    chk("tlbrf_code", bus.excode, 32'h3F);
    chk("tlbrf_badv", bus.badvaddr, 32'h1C000130);
    release_flush("tlbrf");

    // ADEM beats lower memory faults, subcode 1
    accept(32'h1C000140, 4'b0000, 4'b0000, 7'b0111111, 32'h00003004, 0, 0, 0);
    chk("adem_code", bus.excode, 32'h08);
    chk("adem_sub", bus.esubcode, 1);
    chk("adem_badv", bus.badvaddr, 32'h00003004);
    release_flush("adem");

    // lowest priority memory fault PPI_m
    accept(32'h1C000150, 4'b0000, 4'b0000, 7'b0000001, 32'h00004008, 0, 0, 0);
    chk("ppim_code", bus.excode, 32'h07);
    chk("ppim_badv", bus.badvaddr, 32'h00004008);
    release_flush("ppim");

    // BRK beats memory faults
    accept(32'h1C000160, 4'b0000, 4'b0001, 7'b0001000, 32'h0000500C, 0, 0, 0);
    chk("brk_code", bus.excode, 32'h0C);
    chk("brk_badv", bus.badvaddr, 0);
    release_flush("brk");

    // ertn: flush held, exlike at T+2, ready at T+3, exlike in RUN ignored
    accept(32'h1C000300, 4'b0000, 4'b0000, 7'b0000000, 32'h0, 1, 1, 0);
    chk("ertn_ev", bus.is_ertn, 1);
    chk("ertn_fa", bus.is_fetch_again, 0);
    chk("ertn_commit", commit_valid, 1);
    chk("ertn_code", bus.excode, 0);
    chk("ertn_exc", bus.is_exc, 0);
    tick();
    chk("ertn_t2_flush", flush, 1);
    chk("ertn_t2_ready", bus.wb_ready, 0);
    chk("ertn_t2_pulse", bus.is_ertn, 0);
    bus.exlike = 1'b1;
    tick();
    chk("ertn_t3_ready", bus.wb_ready, 1);
    chk("ertn_t3_flush", flush, 0);
    tick();
    bus.exlike = 1'b0;
    chk("exl_run_ready", bus.wb_ready, 1);
    chk("exl_run_flush", flush, 0);

    // refetch with SYS: trap wins
    accept(32'h1C000170, 4'b0000, 4'b0010, 7'b0000000, 32'h0, 0, 1, 0);
    chk("sys_exc", bus.is_exc, 1);
    chk("sys_code", bus.excode, 32'h0B);
    chk("sys_fa", bus.is_fetch_again, 0);
    chk("sys_commit", commit_valid, 0);
    release_flush("sys");

    // plain retire, then idle (ignored in default build)
    accept(32'h1C000180, 4'b0000, 4'b0000, 7'b0000000, 32'h0, 0, 0, 0);
    chk("ret_commit", commit_valid, 1);
    chk("ret_exc", bus.is_exc, 0);
    chk("ret_ready", bus.wb_ready, 1);
    chk("ret_flush", flush, 0);
    tick();
    chk("ret_pulse", commit_valid, 0);
    chk("novalid_ready", bus.wb_ready, 1);

`ifdef IDLE_WAKE_EN
    accept(32'h1C000200, 4'b0000, 4'b0000, 7'b0000000, 32'h0, 0, 0, 1);
    chk("idle_commit", commit_valid, 1);
    chk("idle_ready", bus.wb_ready, 0);
    chk("idle_flush", flush, 0);
    tick(); tick(); tick(); tick();
    chk("idle_wait_ready", bus.wb_ready, 0);
    chk("idle_wait_exc", bus.is_exc, 0);
    bus.ie = 1; bus.is = 12'h800; bus.lie = 12'h800;
    tick();
    bus.ie = 0; bus.is = 0; bus.lie = 0;
    chk("wake_exc", bus.is_exc, 1);
    chk("wake_code", bus.excode, 0);
    chk("wake_pc", bus.csr_pc, 32'h1C000204);
    chk("wake_flush", flush, 1);
    release_flush("wake");
`else
    accept(32'h1C000200, 4'b0000, 4'b0000, 7'b0000000, 32'h0, 0, 0, 1);
    chk("idle_commit", commit_valid, 1);
    chk("idle_exc", bus.is_exc, 0);
    tick();
    chk("idle_ready", bus.wb_ready, 1);
    chk("idle_flush", flush, 0);
`endif

    // refetch event with no exlike: 8 FLUSH cycles then forced RUN
    accept(32'h1C000400, 4'b0000, 4'b0000, 7'b0000000, 32'h0, 0, 1, 0);
    chk("rf_fa", bus.is_fetch_again, 1);
    chk("rf_commit", commit_valid, 1);
    chk("rf_pc", bus.csr_pc, 32'h1C000400);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tmo_flush%0d", i), flush, 1);
      if (i == 7) chk("tmo_pre", flush_timeout, 0);
      tick();
    end
    chk("tmo_flush_end", flush, 0);
    chk("tmo_ready", bus.wb_ready, 1);
    chk("tmo_sticky", flush_timeout, 1);
    tick();
    chk("tmo_sticky2", flush_timeout, 1);

    // reset mid-FLUSH returns to RUN and clears timeout
    accept(32'h1C000500, 4'b0000, 4'b0001, 7'b0000000, 32'h0, 0, 0, 0);
    chk("mid_flush", flush, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", bus.wb_ready, 1);
    chk("mid_rst_flush", flush, 0);
    chk("mid_rst_exc", bus.is_exc, 0);
    chk("mid_rst_tmo", flush_timeout, 0);
    tick();
    reset = 1'b1;
    tick();
    accept(32'h1C000510, 4'b0010, 4'b0000, 7'b0000000, 32'h0, 0, 0, 0);
    chk("post_rst_code", bus.excode, 32'h03);
    chk("post_rst_badv", bus.badvaddr, 32'h1C000510);
    release_flush("post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
